// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the byte-stream to Wishbone writer.
package wb_stream_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned SEL_W      = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Byte-enable mask with the low n lanes set (n = 0..4).
    function automatic logic [SEL_W-1:0] sel_mask(input logic [2:0] n);
        logic [SEL_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            if (i < 32'(n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word and captures
// the byte-enable mask when the word is handed to the bus.
module byte_packer
    import wb_stream_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clr,
    input  logic             i_accept,
    input  logic [7:0]       i_byte,
    input  logic             i_latch,
    output logic [2:0]       o_held_next,
    output logic [31:0]      o_data,
    output logic [SEL_W-1:0] o_sel
);

    logic [2:0]       r_count;
    logic [31:0]      r_data;
    logic [SEL_W-1:0] r_sel;

    // Bytes held once this cycle's accept (if any) is counted.
    assign o_held_next = r_count + 3'(i_accept);
    assign o_data      = r_data;
    assign o_sel       = r_sel;

    // Byte lane write, count advance and sel capture; clear wins over accept.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (i_clr) begin
            r_count <= '0;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            if (i_accept) begin
                r_data[{r_count[1:0], 3'b000} +: 8] <= i_byte;
                r_count                             <= o_held_next;
            end
            if (i_latch) begin
                r_sel <= sel_mask(o_held_next);
            end
        end
    end

endmodule

// File: rtl/wb_stream_writer.sv
// Byte-stream to Wishbone pipelined write master: packs bytes into words,
// issues one single-beat write per word, tracks address, count and errors.
module wb_stream_writer
    import wb_stream_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_data,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [AW-1:0]    i_start_addr,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [AW-1:0]    o_wb_addr,
    output logic [DW-1:0]    o_wb_data,
    output logic [SEL_W-1:0] o_wb_sel,
    input  logic             i_wb_ack,
    input  logic             i_wb_stall,
    input  logic             i_wb_err,
    output logic             o_err,
    output logic [15:0]      o_words
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_words;
    logic          r_err;

    logic          w_accept;
    logic          w_clr;
    logic          w_latch;
    logic          w_complete;
    logic          w_load;
    logic          w_set_err;
    logic [2:0]    w_held_next;

    // Kept outside the FSM block so the packer's held count does not feed back into it.
    assign w_accept = (r_state == FILL) && i_valid && !i_start;

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_clr       (w_clr),
        .i_accept    (w_accept),
        .i_byte      (i_data),
        .i_latch     (w_latch),
        .o_held_next (w_held_next),
        .o_data      (o_wb_data),
        .o_sel       (o_wb_sel)
    );

    assign o_wb_addr = r_addr;
    assign o_words   = r_words;
    assign o_err     = r_err;

    // State register; reset drops cyc/stb at once since they decode from it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, bus controls and datapath strobes.
    always_comb begin
        w_next     = r_state;
        o_ready    = 1'b0;
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        w_clr      = 1'b0;
        w_latch    = 1'b0;
        w_complete = 1'b0;
        w_load     = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            FILL: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_load = 1'b1;
                    w_clr  = 1'b1;
                end else if ((w_held_next == 3'd4) ||
                             (i_flush && (w_held_next != 3'd0))) begin
                    w_latch = 1'b1;
                    w_next  = REQ;
                end
            end
            REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                o_wb_we  = 1'b1;
                if (i_wb_err) begin
                    w_set_err = 1'b1;
                    w_next    = ERR;
                end else if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        w_complete = 1'b1;
                        w_clr      = 1'b1;
                        w_next     = FILL;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                o_wb_cyc = 1'b1;
                o_wb_we  = 1'b1;
                if (i_wb_err) begin
                    w_set_err = 1'b1;
                    w_next    = ERR;
                end else if (i_wb_ack) begin
                    w_complete = 1'b1;
                    w_clr      = 1'b1;
                    w_next     = FILL;
                end
            end
            ERR: begin
                if (i_start) begin
                    w_load = 1'b1;
                    w_clr  = 1'b1;
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    // Address, acknowledged-word count and sticky error flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr  <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr <= i_start_addr;
                r_err  <= 1'b0;
            end else if (w_complete) begin
                r_addr  <= r_addr + 1'b1;
                r_words <= r_words + 16'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
